// File: rtl/lae_sequencer.sv
// lae_sequencer
// -----------------------------------------------------------------------------
// Session-level sequencer for the 192-bit threshold-implementation
// authenticated-encryption core. A host session command walks the round
// datapath through START -> INIT -> [AD] -> [MSG] -> FINAL -> TAG.
// Host block transfers (AD / message) use a valid/ready handshake.
//
// Optional feature macro: LAE_SEQ_RNG_STALL_EN
//   defined   : every round cycle also needs rng_valid=1 (fresh masks).
//               INIT/FINAL hold the counter while rng_valid=0; in AD/MSG,
//               in_ready follows rng_valid.
//   undefined : rng_valid is ignored and rounds proceed unconditionally.
//
// Ports
//   ck, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       session request handshake (IDLE only)
//   cmd_has_ad, cmd_has_msg   session shape, sampled with cmd_valid
//   in_valid/in_last/in_ready host block stream for AD and message phases
//   rng_valid                 mask randomness available
//   core_start                one-cycle datapath reset pulse
//   core_ain/core_min         absorb AD / process message block this cycle
//   core_round                datapath performs one round this cycle
//   core_rcon                 round constant {2'b0, counter}
//   tag_valid/tag_ready       tag hand-off to the host
//   busy                      session in progress
// -----------------------------------------------------------------------------
module lae_sequencer #(
  parameter int INIT_ROUNDS  = 16,
  parameter int FINAL_ROUNDS = 16
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_has_ad,
  input  logic       cmd_has_msg,
  output logic       cmd_ready,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       rng_valid,
  output logic       core_start,
  output logic       core_ain,
  output logic       core_min,
  output logic       core_round,
  output logic [5:0] core_rcon,
  output logic       tag_valid,
  input  logic       tag_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_INIT  = 3'd2,
    S_AD    = 3'd3,
    S_MSG   = 3'd4,
    S_FINAL = 3'd5,
    S_TAG   = 3'd6
  } state_t;

  // Counter value on the last round of each fixed-length phase.
  localparam logic [3:0] INIT_LAST  = 4'(INIT_ROUNDS - 1);
  localparam logic [3:0] FINAL_LAST = 4'(FINAL_ROUNDS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       has_ad_q, has_ad_d;
  logic       has_msg_q, has_msg_d;
  logic       rng_ok;
  logic       blk_hs;

`ifdef LAE_SEQ_RNG_STALL_EN
  assign rng_ok = rng_valid;
`else
  // Randomness is not gating rounds in this build.
  logic unused_rng;
  assign unused_rng = rng_valid;
  assign rng_ok     = 1'b1;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      has_ad_q  <= 1'b0;
      has_msg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      has_ad_q  <= has_ad_d;
      has_msg_q <= has_msg_d;
    end
  end

  // Block handshake; in_ready is only ever high in AD/MSG.
  assign blk_hs = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    has_ad_d   = has_ad_q;
    has_msg_d  = has_msg_q;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    core_start = 1'b0;
    core_ain   = 1'b0;
    core_min   = 1'b0;
    core_round = 1'b0;
    tag_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    core_rcon  = {2'b00, cnt_q};

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          has_ad_d  = cmd_has_ad;
          has_msg_d = cmd_has_msg;
          state_d   = S_START;
        end
      end

      S_START: begin
        core_start = 1'b1;
        cnt_d      = 4'd0;
        state_d    = S_INIT;
      end

      S_INIT: begin
        if (rng_ok) begin
          core_round = 1'b1;
          if (cnt_q == INIT_LAST) begin
            cnt_d = 4'd0;
            if (has_ad_q)       state_d = S_AD;
            else if (has_msg_q) state_d = S_MSG;
            else                state_d = S_FINAL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_AD: begin
        in_ready = rng_ok;
        if (blk_hs) begin
          core_round = 1'b1;
          core_ain   = 1'b1;
          if (in_last) begin
            cnt_d   = 4'd0;
            state_d = has_msg_q ? S_MSG : S_FINAL;
          end else begin
            // 4-bit counter wraps 15 -> 0 on long phases.
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_MSG: begin
        in_ready = rng_ok;
        if (blk_hs) begin
          core_round = 1'b1;
          core_min   = 1'b1;
          if (in_last) begin
            cnt_d   = 4'd0;
            state_d = S_FINAL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_FINAL: begin
        if (rng_ok) begin
          core_round = 1'b1;
          if (cnt_q == FINAL_LAST) begin
            cnt_d   = 4'd0;
            state_d = S_TAG;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_TAG: begin
        tag_valid = 1'b1;
        if (tag_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lae_sequencer.sv
module tb_lae_sequencer;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_has_ad, cmd_has_msg, cmd_ready;
  logic       in_valid, in_last, in_ready;
  logic       rng_valid;
  logic       core_start, core_ain, core_min, core_round;
  logic [5:0] core_rcon;
  logic       tag_valid, tag_ready, busy;

`ifdef LAE_SEQ_RNG_STALL_EN
  localparam logic RNG_DEF = 1'b1;
`else
  localparam logic RNG_DEF = 1'b0;
`endif

  lae_sequencer #(.INIT_ROUNDS(16), .FINAL_ROUNDS(16)) dut (
    .ck(ck), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_has_ad(cmd_has_ad), .cmd_has_msg(cmd_has_msg),
    .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .rng_valid(rng_valid),
    .core_start(core_start), .core_ain(core_ain), .core_min(core_min),
    .core_round(core_round), .core_rcon(core_rcon),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .busy(busy)
  );

  always #5 ck = ~ck;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc   = 0;
  int n_round, n_ain, n_min, n_start, n_tag;

  // Expected round records {ain, min, rcon[5:0]} in order of occurrence.
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
    cyc++;
  endtask

  task automatic push_rounds(input int n, input logic ain, input logic min);
    for (int i = 0; i < n; i++) sb.push_back({ain, min, 6'(i % 16)});
  endtask

  task automatic clear_counts();
    n_round = 0; n_ain = 0; n_min = 0; n_start = 0; n_tag = 0;
    sb.delete();
  endtask

  task automatic accept(input logic ad, input logic msg);
    cmd_valid   = 1'b1;
    cmd_has_ad  = ad;
    cmd_has_msg = msg;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tag(input int exp_lat, input string name);
    int g;
    g = 0;
    while (tag_valid !== 1'b1 && g < 200) begin
      step();
      g++;
    end
    check(name, 32'(cyc - acc), 32'(exp_lat));
  endtask

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 100) begin
      step();
      g++;
    end
    check(name, 32'(in_ready), 32'd1);
  endtask

  task automatic take_tag();
    tag_ready = 1'b1;
    step();
    tag_ready = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge ck) begin
    if (rst_n) begin
      check("ain_min_excl", 32'(core_ain & core_min), 32'd0);
      if (core_start) n_start++;
      if (tag_valid)  n_tag++;
      if (core_round) begin
        n_round++;
        if (core_ain) n_ain++;
        if (core_min) n_min++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(core_rcon), 32'hFFFF);
        end else begin
          check("round_rec", 32'({core_ain, core_min, core_rcon}), 32'(sb.pop_front()));
        end
      end else begin
        check("noround_ctl", 32'({core_ain, core_min}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_has_ad = 1'b0; cmd_has_msg = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; tag_ready = 1'b0;
    rng_valid = RNG_DEF;
    clear_counts();
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tag_valid", 32'(tag_valid), 32'd0);
    check("rst_core", 32'({core_start, core_ain, core_min, core_round}), 32'd0);
    check("rst_rcon", 32'(core_rcon), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Empty session: 16 INIT + 16 FINAL rounds, tag at accept+34.
    clear_counts();
    push_rounds(16, 1'b0, 1'b0);
    push_rounds(16, 1'b0, 1'b0);
    accept(1'b0, 1'b0);
    check("empty_start", 32'(core_start), 32'd1);
    check("empty_busy", 32'(busy), 32'd1);
    wait_tag(34, "empty_lat");
    check("empty_rounds", 32'(n_round), 32'd32);
    check("empty_nstart", 32'(n_start), 32'd1);
    take_tag();
    check("empty_ntag", 32'(n_tag), 32'd1);
    check("empty_idle", 32'({cmd_ready, busy, tag_valid}), 32'b100);
    check("empty_sb", 32'(sb.size()), 32'd0);
    step();

    // 3 AD + 2 MSG blocks, gapped every other cycle.
    clear_counts();
    push_rounds(16, 1'b0, 1'b0);
    push_rounds(3, 1'b1, 1'b0);
    push_rounds(2, 1'b0, 1'b1);
    push_rounds(16, 1'b0, 1'b0);
    accept(1'b1, 1'b1);
    wait_ready("ad_ready");
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_last  = (b == 2) || (b == 4);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (b < 4) step();
    end
    check("gap_final_entry", 32'({in_ready, core_round}), 32'b01);
    wait_tag(43, "gap_lat");
    check("gap_nain", 32'(n_ain), 32'd3);
    check("gap_nmin", 32'(n_min), 32'd2);
    take_tag();
    check("gap_sb", 32'(sb.size()), 32'd0);
    step();

    // 20 back-to-back message blocks, then tag withheld 10 cycles.
    clear_counts();
    push_rounds(16, 1'b0, 1'b0);
    push_rounds(20, 1'b0, 1'b1);
    push_rounds(16, 1'b0, 1'b0);
    accept(1'b0, 1'b1);
    wait_ready("msg_ready");
    in_valid = 1'b1;
    for (int b = 0; b < 20; b++) begin
      in_last = (b == 19);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("msg_final_next", 32'({in_ready, core_round, core_rcon}), 32'({1'b0, 1'b1, 6'd0}));
    wait_tag(54, "msg_lat");
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("tag_hold", 32'({tag_valid, cmd_ready}), 32'b10);
      step();
    end
    cmd_valid = 1'b0;
    check("tag_hold_last", 32'(tag_valid), 32'd1);
    take_tag();
    check("msg_ntag", 32'(n_tag), 32'd11);
    check("msg_nmin", 32'(n_min), 32'd20);
    step();
    check("tag_cmd_ignored", 32'({cmd_ready, busy, 4'(n_start)}), 32'({1'b1, 1'b0, 4'd1}));
    check("msg_sb", 32'(sb.size()), 32'd0);

    // Reset asserted in the middle of INIT.
    clear_counts();
    push_rounds(5, 1'b0, 1'b0);
    accept(1'b1, 1'b1);
    begin
      int g;
      g = 0;
      while (!(core_round === 1'b1 && core_rcon == 6'd5) && g < 50) begin
        step();
        g++;
      end
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_idle", 32'({cmd_ready, busy}), 32'b10);
    check("mid_rst_core", 32'({core_start, core_ain, core_min, core_round, in_ready, tag_valid}), 32'd0);
    check("mid_rst_rcon", 32'(core_rcon), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'({cmd_ready, busy}), 32'b10);
    check("post_rst_sb", 32'(sb.size()), 32'd0);

`ifdef LAE_SEQ_RNG_STALL_EN
    // rng_valid low for 4 cycles at FINAL round 7.
    clear_counts();
    push_rounds(16, 1'b0, 1'b0);
    push_rounds(16, 1'b0, 1'b0);
    accept(1'b0, 1'b0);
    repeat (24) step();
    check("rng_pre", 32'({core_round, core_rcon}), 32'({1'b1, 6'd7}));
    rng_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      #1;
      check("rng_stall", 32'({core_round, core_rcon}), 32'({1'b0, 6'd7}));
    end
    step();
    rng_valid = 1'b1;
    wait_tag(38, "rng_lat");
    take_tag();
    check("rng_sb", 32'(sb.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
